// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage branch resolution. Holds the decode-stage control/PC state in
// the E-stage register, resolves conditional branches, JAL and JALR against the
// forwarded operands, and reports the outcome back to the fetch-stage
// predictor. Branch and mispredict statistics are also tracked.
//
// Optional feature: define PERF_COUNTERS_EN to build the saturating
// BranchCount / MispredCount counters. Without it both outputs are tied to 0.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   StallE, FlushE        hold / bubble the E-stage register (flush wins)
//   BranchD, JumpD, JalrD decode-stage instruction class
//   Predict_branchD       fetch-time taken prediction
//   funct3D               branch condition select
//   PCD, PCPlus4D         instruction PC and PC+4
//   ImmExtD               sign-extended immediate
//   SrcAE, SrcBE          forwarded rs1/rs2 for the E-stage instruction
//   PCSrcE, PCTargetE     fetch redirect and redirect/update target
//   Eval_branch           actual outcome for predictor update
//   StateUpdateEnable     predictor update strobe
//   jalr                  E-stage instruction is JALR
//   MispredictE           resolved outcome differs from prediction
//   BranchCount           resolved branch/jump count
//   MispredCount          mispredict (redirect) count
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             JalrD,
  input  logic             Predict_branchD,
  input  logic [2:0]       funct3D,
  input  logic [31:0]      PCD,
  input  logic [31:0]      PCPlus4D,
  input  logic [31:0]      ImmExtD,
  input  logic [31:0]      SrcAE,
  input  logic [31:0]      SrcBE,
  output logic             PCSrcE,
  output logic [31:0]      PCTargetE,
  output logic             Eval_branch,
  output logic             StateUpdateEnable,
  output logic             jalr,
  output logic             MispredictE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  // E-stage register
  logic        branch_q, jump_q, jalr_q, predict_q;
  logic [2:0]  funct3_q;
  logic [31:0] pc_q, pc_plus4_q, imm_q;

  // Set once a stalled instruction has already redirected / updated the
  // predictor, so holding it in E does not repeat those side effects.
  logic fired_q, fired_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      jalr_q      <= 1'b0;
      predict_q   <= 1'b0;
      funct3_q    <= 3'b000;
      pc_q        <= RESET_PC;
      pc_plus4_q  <= RESET_PC;
      imm_q       <= 32'h0;
    end else if (FlushE) begin
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      jalr_q      <= 1'b0;
      predict_q   <= 1'b0;
      funct3_q    <= 3'b000;
      pc_q        <= RESET_PC;
      pc_plus4_q  <= RESET_PC;
      imm_q       <= 32'h0;
    end else if (!StallE) begin
      branch_q    <= BranchD;
      jump_q      <= JumpD;
      jalr_q      <= JalrD;
      predict_q   <= Predict_branchD;
      funct3_q    <= funct3D;
      pc_q        <= PCD;
      pc_plus4_q  <= PCPlus4D;
      imm_q       <= ImmExtD;
    end
  end

  // Resolution datapath
  logic        cond;
  logic        is_ctrl;
  logic        taken;
  logic [31:0] target;

  always_comb begin
    cond = 1'b0;
    case (funct3_q)
      3'b000:  cond = (SrcAE == SrcBE);
      3'b001:  cond = (SrcAE != SrcBE);
      3'b100:  cond = ($signed(SrcAE) <  $signed(SrcBE));
      3'b101:  cond = ($signed(SrcAE) >= $signed(SrcBE));
      3'b110:  cond = (SrcAE <  SrcBE);
      3'b111:  cond = (SrcAE >= SrcBE);
      default: cond = 1'b0;
    endcase
  end

  assign is_ctrl = branch_q | jump_q | jalr_q;
  assign taken   = (branch_q & cond) | jump_q | jalr_q;
  // JALR clears bit 0 of the computed address.
  assign target  = jalr_q ? ((SrcAE + imm_q) & ~32'h1) : (pc_q + imm_q);

  assign PCTargetE         = taken ? target : pc_plus4_q;
  // JALR is never predicted, so it always redirects.
  assign MispredictE       = ((branch_q | jump_q) & (taken != predict_q)) | jalr_q;
  assign PCSrcE            = MispredictE & ~fired_q;
  assign StateUpdateEnable = is_ctrl & ~fired_q;
  assign Eval_branch       = taken & (branch_q | jump_q);
  assign jalr              = jalr_q;

  // Cleared whenever the E register takes new contents (load or flush);
  // otherwise sticky once a control instruction has been seen while stalled.
  always_comb begin
    fired_d = fired_q;
    if (FlushE || !StallE) begin
      fired_d = 1'b0;
    end else if (is_ctrl) begin
      fired_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fired_q <= 1'b0;
    end else begin
      fired_q <= fired_d;
    end
  end

`ifdef PERF_COUNTERS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  // Saturating counters: stop at all-ones, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (StateUpdateEnable && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + CNT_ONE;
      end
      if (PCSrcE && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_ONE;
      end
    end
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;
`else
  assign BranchCount  = '0;
  assign MispredCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int          CNT_W    = 2;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0080;
`ifdef PERF_COUNTERS_EN
  localparam int          SAT_EXP  = 3;
`else
  localparam int          SAT_EXP  = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             StallE, FlushE;
  logic             BranchD, JumpD, JalrD, Predict_branchD;
  logic [2:0]       funct3D;
  logic [31:0]      PCD, PCPlus4D, ImmExtD, SrcAE, SrcBE;
  logic             PCSrcE, Eval_branch, StateUpdateEnable, jalr, MispredictE;
  logic [31:0]      PCTargetE;
  logic [CNT_W-1:0] BranchCount, MispredCount;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .BranchD(BranchD), .JumpD(JumpD), .JalrD(JalrD),
    .Predict_branchD(Predict_branchD), .funct3D(funct3D),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .SrcAE(SrcAE), .SrcBE(SrcBE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .Eval_branch(Eval_branch),
    .StateUpdateEnable(StateUpdateEnable), .jalr(jalr),
    .MispredictE(MispredictE), .BranchCount(BranchCount),
    .MispredCount(MispredCount)
  );

  int checks = 0;
  int errors = 0;
  bit run_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The instruction sitting in E, plus whether its side effects were already
  // reported to fetch during a stall.
  typedef struct packed {
    logic        br, jp, jr, pred;
    logic [2:0]  f3;
    logic [31:0] pc, pc4, imm;
    logic        reported;
  } e_t;

  e_t m;
  int m_bcnt, m_mcnt;

  function automatic e_t bubble_e();
    e_t e;
    e = '0;
    e.pc  = RESET_PC;
    e.pc4 = RESET_PC;
    return e;
  endfunction

  function automatic e_t load_e();
    e_t e;
    e = '0;
    e.br = BranchD; e.jp = JumpD; e.jr = JalrD; e.pred = Predict_branchD;
    e.f3 = funct3D; e.pc = PCD; e.pc4 = PCPlus4D; e.imm = ImmExtD;
    return e;
  endfunction

  function automatic logic rv_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic x_taken();
    return (m.br && rv_cond(m.f3, SrcAE, SrcBE)) || m.jp || m.jr;
  endfunction
  function automatic logic [31:0] x_target();
    if (!x_taken()) return m.pc4;
    if (m.jr)       return (SrcAE + m.imm) & 32'hFFFF_FFFE;
    return m.pc + m.imm;
  endfunction
  function automatic logic x_mis();
    return m.jr || ((m.br || m.jp) && (x_taken() != m.pred));
  endfunction
  function automatic logic x_pcsrc();
    return x_mis() && !m.reported;
  endfunction
  function automatic logic x_sue();
    return (m.br || m.jp || m.jr) && !m.reported;
  endfunction
  function automatic logic x_eval();
    return x_taken() && (m.br || m.jp);
  endfunction
  function automatic int x_bcnt();
`ifdef PERF_COUNTERS_EN
    return m_bcnt;
`else
    return 0;
`endif
  endfunction
  function automatic int x_mcnt();
`ifdef PERF_COUNTERS_EN
    return m_mcnt;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m      <= bubble_e();
      m_bcnt <= 0;
      m_mcnt <= 0;
    end else begin
      if (x_sue()   && m_bcnt < CNT_MAX) m_bcnt <= m_bcnt + 1;
      if (x_pcsrc() && m_mcnt < CNT_MAX) m_mcnt <= m_mcnt + 1;
      if (FlushE)                 m <= bubble_e();
      else if (!StallE)           m <= load_e();
      else if (m.br || m.jp || m.jr) m.reported <= 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_checks) begin
      chk("PCSrcE",            {31'd0, PCSrcE},            {31'd0, x_pcsrc()});
      chk("PCTargetE",         PCTargetE,                  x_target());
      chk("Eval_branch",       {31'd0, Eval_branch},       {31'd0, x_eval()});
      chk("StateUpdateEnable", {31'd0, StateUpdateEnable}, {31'd0, x_sue()});
      chk("jalr",              {31'd0, jalr},              {31'd0, m.jr});
      chk("MispredictE",       {31'd0, MispredictE},       {31'd0, x_mis()});
      chk("BranchCount",       32'(BranchCount),           32'(x_bcnt()));
      chk("MispredCount",      32'(MispredCount),          32'(x_mcnt()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_d();
    BranchD = 0; JumpD = 0; JalrD = 0; Predict_branchD = 0;
    funct3D = 3'd0; PCD = 32'h0; PCPlus4D = 32'h0; ImmExtD = 32'h0;
  endtask

  // Put one instruction into E for exactly one cycle, followed by a bubble.
  // Returns just after the negedge on which that instruction is in E.
  task automatic issue(input logic br, input logic jp, input logic jr, input logic pred,
                       input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b);
    BranchD = br; JumpD = jp; JalrD = jr; Predict_branchD = pred;
    funct3D = f3; PCD = pc; PCPlus4D = pc + 32'd4; ImmExtD = imm;
    SrcAE = a; SrcBE = b;
    @(posedge clk); #1;
    clear_d();
    @(negedge clk); #1;
    $display("txn br=%0b jp=%0b jr=%0b pred=%0b f3=%0d pc=%08h -> PCSrcE=%0b tgt=%08h eval=%0b sue=%0b mis=%0b",
             br, jp, jr, pred, f3, pc, PCSrcE, PCTargetE, Eval_branch, StateUpdateEnable, MispredictE);
  endtask

  initial begin
    rst = 1; StallE = 0; FlushE = 0; SrcAE = 0; SrcBE = 0;
    clear_d();
    #12;
    chk("rst PCSrcE",       {31'd0, PCSrcE}, 32'd0);
    chk("rst PCTargetE",    PCTargetE, RESET_PC);
    chk("rst SUE",          {31'd0, StateUpdateEnable}, 32'd0);
    chk("rst BranchCount",  32'(BranchCount), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    run_checks = 1;

    // 1: beq taken, predicted not taken
    issue(1, 0, 0, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5);
    chk("t1 PCSrcE",    {31'd0, PCSrcE}, 32'd1);
    chk("t1 PCTargetE", PCTargetE, 32'h120);
    chk("t1 Eval",      {31'd0, Eval_branch}, 32'd1);
    chk("t1 SUE",       {31'd0, StateUpdateEnable}, 32'd1);
    chk("t1 Mis",       {31'd0, MispredictE}, 32'd1);

    // 2: bne not taken, predicted taken -> redirect to PC+4
    issue(1, 0, 0, 1, 3'd1, 32'h200, 32'h40, 32'd7, 32'd7);
    chk("t2 PCSrcE",    {31'd0, PCSrcE}, 32'd1);
    chk("t2 PCTargetE", PCTargetE, 32'h204);
    chk("t2 Eval",      {31'd0, Eval_branch}, 32'd0);

    // 3: blt signed (-1 < 1) taken, predicted taken
    issue(1, 0, 0, 1, 3'd4, 32'h300, 32'h10, 32'hFFFF_FFFF, 32'd1);
    chk("t3 blt PCSrcE", {31'd0, PCSrcE}, 32'd0);
    chk("t3 blt SUE",    {31'd0, StateUpdateEnable}, 32'd1);
    chk("t3 blt Eval",   {31'd0, Eval_branch}, 32'd1);
    // bltu (0xFFFFFFFF < 1 false) not taken, predicted not taken
    issue(1, 0, 0, 0, 3'd6, 32'h310, 32'h10, 32'hFFFF_FFFF, 32'd1);
    chk("t3 bltu PCSrcE", {31'd0, PCSrcE}, 32'd0);
    chk("t3 bltu tgt",    PCTargetE, 32'h314);
    // bge / bgeu / reserved funct3
    issue(1, 0, 0, 0, 3'd5, 32'h320, 32'h8, 32'd1, 32'hFFFF_FFFF);
    issue(1, 0, 0, 1, 3'd7, 32'h330, 32'h8, 32'd1, 32'hFFFF_FFFF);
    issue(1, 0, 0, 1, 3'd2, 32'h340, 32'h8, 32'd3, 32'd3);
    chk("f3=010 Eval", {31'd0, Eval_branch}, 32'd0);

    // 4: JALR clears bit 0
    issue(0, 0, 1, 0, 3'd0, 32'h400, 32'h4, 32'h1003, 32'd0);
    chk("t4 PCSrcE",    {31'd0, PCSrcE}, 32'd1);
    chk("t4 jalr",      {31'd0, jalr}, 32'd1);
    chk("t4 PCTargetE", PCTargetE, 32'h1006);
    chk("t4 Eval",      {31'd0, Eval_branch}, 32'd0);
    // JAL backwards with wrap, correctly predicted
    issue(0, 1, 0, 1, 3'd0, 32'h500, 32'hFFFF_FFF0, 32'd0, 32'd0);
    chk("jal PCTargetE", PCTargetE, 32'h4F0);
    chk("jal PCSrcE",    {31'd0, PCSrcE}, 32'd0);

    // 5: mispredicted branch held for 3 stalled cycles
    BranchD = 1; funct3D = 3'd0; PCD = 32'h600; PCPlus4D = 32'h604; ImmExtD = 32'h30;
    SrcAE = 32'd9; SrcBE = 32'd9;
    @(posedge clk); #1;
    StallE = 1;
    clear_d();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      $display("txn stall cycle %0d -> PCSrcE=%0b sue=%0b", c, PCSrcE, StateUpdateEnable);
      chk("t5 stall PCSrcE", {31'd0, PCSrcE}, (c == 0) ? 32'd1 : 32'd0);
      chk("t5 stall SUE",    {31'd0, StateUpdateEnable}, (c == 0) ? 32'd1 : 32'd0);
      chk("t5 stall tgt",    PCTargetE, 32'h630);
      @(posedge clk); #1;
    end
    FlushE = 1;
    @(posedge clk); #1;
    FlushE = 0; StallE = 0;
    @(negedge clk); #1;
    $display("txn flush-with-stall -> PCSrcE=%0b tgt=%08h", PCSrcE, PCTargetE);
    chk("t5 flush PCSrcE", {31'd0, PCSrcE}, 32'd0);
    chk("t5 flush SUE",    {31'd0, StateUpdateEnable}, 32'd0);
    chk("t5 flush Mis",    {31'd0, MispredictE}, 32'd0);
    chk("t5 flush tgt",    PCTargetE, RESET_PC);

    // 6: counters saturate after 5 mispredicts
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("t6 rst BranchCount",  32'(BranchCount), 32'd0);
    chk("t6 rst MispredCount", 32'(MispredCount), 32'd0);
    #1 rst = 0;
    @(posedge clk); #1;
    for (int n = 0; n < 5; n++)
      issue(1, 0, 0, 0, 3'd0, 32'h700 + 32'(n * 8), 32'h40, 32'd1, 32'd1);
    @(posedge clk); #1;
    chk("t6 BranchCount",  32'(BranchCount), 32'(SAT_EXP));
    chk("t6 MispredCount", 32'(MispredCount), 32'(SAT_EXP));

    // asynchronous reset in the middle of a stall
    BranchD = 1; funct3D = 3'd0; PCD = 32'h800; PCPlus4D = 32'h804; ImmExtD = 32'h10;
    @(posedge clk); #1;
    StallE = 1;
    clear_d();
    @(negedge clk); #1;
    rst = 1;
    #1;
    $display("txn async reset mid-stall -> PCSrcE=%0b tgt=%08h cnt=%0d", PCSrcE, PCTargetE, BranchCount);
    chk("arst PCSrcE",       {31'd0, PCSrcE}, 32'd0);
    chk("arst SUE",          {31'd0, StateUpdateEnable}, 32'd0);
    chk("arst PCTargetE",    PCTargetE, RESET_PC);
    chk("arst BranchCount",  32'(BranchCount), 32'd0);
    chk("arst MispredCount", 32'(MispredCount), 32'd0);
    #1 rst = 0;
    StallE = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage branch resolution block; the producer side of the fetch-stage predictor interface. It registers decode-stage control and PC state into the E stage and resolves conditional branches, JAL and JALR against the forwarded operands. It compares the outcome with the fetch-time prediction and drives PCSrcE/PCTargetE redirect plus predictor-update strobes (Eval_branch, StateUpdateEnable, jalr) back to fetch. It also tracks branch and mispredict statistics.

Parameters:
CNT_W, 16, width of the saturating performance counters
RESET_PC, 32'h0, value loaded into the E-stage PC/PCPlus4 registers on reset or flush

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
StallE  input  1  hold E-stage register contents
FlushE  input  1  load bubble into E-stage register
BranchD  input  1  decode: conditional branch
JumpD  input  1  decode: JAL
JalrD  input  1  decode: JALR
Predict_branchD  input  1  fetch-time taken prediction carried through D
funct3D  input  3  branch condition select
PCD  input  32  instruction PC
PCPlus4D  input  32  PC+4
ImmExtD  input  32  sign-extended immediate
SrcAE  input  32  forwarded rs1 value (E stage, combinational)
SrcBE  input  32  forwarded rs2 value (E stage, combinational)
PCSrcE  output  1  redirect fetch this cycle
PCTargetE  output  32  redirect / predictor-update target
Eval_branch  output  1  actual outcome (1 = taken) for predictor update
StateUpdateEnable  output  1  predictor update strobe
jalr  output  1  E-stage instruction is JALR
MispredictE  output  1  resolved outcome differs from prediction
BranchCount  output  CNT_W  resolved branch/jump count
MispredCount  output  CNT_W  mispredict count

Behaviour:
- E register: Branch/Jump/Jalr/Predict, funct3, PC, PCPlus4, Imm. rst or FlushE -> control bits 0, PC/PCPlus4 = RESET_PC, Imm/funct3 = 0. FlushE has priority over StallE. Else load from D when !StallE; hold when StallE.
- Condition from E register (combinational, zero added latency): funct3 000 beq (A==B), 001 bne, 100 blt signed, 101 bge signed, 110 bltu, 111 bgeu; 010/011 -> not taken.
- TakenE = (BranchE & cond) | JumpE | JalrE.
- Target: JALR -> (SrcAE + ImmE) & ~32'h1; else PCE + ImmE; 32-bit wrap, carry discarded.
- PCTargetE = TakenE ? target : PCPlus4E.
- MispredictE = (BranchE|JumpE) & (TakenE != PredictE), or JalrE (JALR is always redirected; it is never predicted).
- One-shot flag `fired`: set when an event issues while StallE=1. Cleared when the E register loads or flushes. Held in reset = 0.
- PCSrcE = MispredictE & !fired.
- StateUpdateEnable = (BranchE|JumpE|JalrE) & !fired.
- Eval_branch = TakenE & (BranchE|JumpE).
- jalr = JalrE.
- A stalled instruction therefore redirects and updates the predictor exactly once.
- Bubble (all control 0): PCSrcE = StateUpdateEnable = Eval_branch = MispredictE = 0.
- Reset values: all 1-bit outputs 0. PCTargetE = RESET_PC+0 path, i.e. PCPlus4E = RESET_PC. Counters 0.
- Reset mid-stall clears `fired` and the E register asynchronously.

Optional Feature:
Macro PERF_COUNTERS_EN.
- Defined: BranchCount increments on each StateUpdateEnable cycle. MispredCount increments on each PCSrcE cycle. Both saturate at all-ones and never wrap. Both are cleared only by rst.
- Undefined: no counter flops; BranchCount and MispredCount are tied to 0.

Test Plan:
1. beq, PCD=0x100, Imm=0x20, SrcA=SrcB=5, Predict=0 -> next cycle PCSrcE=1, PCTargetE=0x120, Eval_branch=1, StateUpdateEnable=1, MispredictE=1.
2. bne, PCD=0x200, PCPlus4D=0x204, SrcA=SrcB=7, Predict=1 -> PCSrcE=1, PCTargetE=0x204, Eval_branch=0.
3. blt, SrcA=0xFFFFFFFF, SrcB=1, Predict=1 -> taken, PCSrcE=0, StateUpdateEnable=1. bltu with the same operands, Predict=0 -> not taken, PCSrcE=0.
4. JALR, SrcA=0x1003, Imm=0x4 -> PCSrcE=1, jalr=1, PCTargetE=0x1006.
5. Mispredicted branch held with StallE=1 for 3 cycles -> PCSrcE and StateUpdateEnable high only in the first cycle. FlushE asserted with StallE -> bubble loaded, all strobes 0.
6. With PERF_COUNTERS_EN and CNT_W=2: 5 mispredicted branches -> BranchCount=3, MispredCount=3 (saturated). Assert rst -> both 0 immediately.
